// File: rtl/mmio_uart_responder_if.sv
// CPU memory-port bundle seen by the MMIO responder: address, write strobe and
// data from the CPU, read data from Memoria, and the gated strobe / muxed read
// data handed back.
interface mmio_uart_responder_if;
  logic [31:0] addr;
  logic        mem_wr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        mem_wr_gated;

  // Responder side
  modport slave (
    input  addr, mem_wr, wdata, mem_rdata,
    output rdata, mem_wr_gated
  );

  // CPU / Memoria side
  modport master (
    output addr, mem_wr, wdata, mem_rdata,
    input  rdata, mem_wr_gated
  );
endinterface

// File: rtl/mmio_uart_responder.sv
// MMIO responder: a 256-byte window at BASE_ADDR holding a TX FIFO feeding an
// 8N1 transmitter, a free-running timer with compare, and a maskable IRQ.
// Accesses outside the window pass through to Memoria; reads inside the window
// keep Memoria's one-cycle latency.
module mmio_uart_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_uart_responder_if.slave    bus,
  output logic                    tx,
  output logic                    irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [5:0] OFF_TXDATA = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_TIMER  = 6'h02;
  localparam logic [5:0] OFF_CMP    = 6'h03;
  localparam logic [5:0] OFF_PEND   = 6'h04;
  localparam logic [5:0] OFF_EN     = 6'h05;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // Address decode
  logic       hit, wr_hit;
  logic [5:0] off;
  logic       unused_addr_bits;

  assign hit              = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign off              = bus.addr[7:2];
  assign wr_hit           = bus.mem_wr & hit;
  assign unused_addr_bits = ^bus.addr[1:0];
  assign bus.mem_wr_gated = bus.mem_wr & ~hit;

  // Register state
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   cmp_q, cmp_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    en_q, en_d;
  logic          irq_q;
  logic          sel_q;
  logic [31:0]   rd_q, rd_d;

  // Transmitter state
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop, frame_done;

  logic full, empty, busy, push_req, push;
  logic [7:0] head;

  assign full     = (count_q == 4'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != IDLE);
  assign push_req = wr_hit && (off == OFF_TXDATA);
  assign push     = push_req && !full;
  assign head     = fifo_q[rptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO pointers, occupancy and overflow flag
  always_comb begin
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_hit && (off == OFF_STATUS) && bus.wdata[3]) ovf_d = 1'b0;
    if (push_req && full)                              ovf_d = 1'b1;
  end

  // Timer, compare, interrupt pending/enable; a set beats a same-cycle W1C
  always_comb begin
    logic [1:0] set_v, clr_v;
    timer_d = (wr_hit && (off == OFF_TIMER)) ? bus.wdata : timer_q + 32'd1;
    cmp_d   = (wr_hit && (off == OFF_CMP))   ? bus.wdata : cmp_q;
    en_d    = (wr_hit && (off == OFF_EN))    ? bus.wdata[1:0] : en_q;
    set_v   = {frame_done, (timer_q == cmp_q)};
    clr_v   = (wr_hit && (off == OFF_PEND))  ? bus.wdata[1:0] : 2'b00;
    pend_d  = (pend_q & ~clr_v) | set_v;
  end

  // Read mux for the window, sampled into rd_q every edge
  always_comb begin
    rd_d = '0;
    case (off)
      OFF_STATUS: rd_d = {24'h0, count_q, ovf_q, busy, empty, full};
      OFF_TIMER:  rd_d = timer_q;
      OFF_CMP:    rd_d = cmp_q;
      OFF_PEND:   rd_d = {30'h0, pend_q};
      OFF_EN:     rd_d = {30'h0, en_q};
      default:    rd_d = '0;
    endcase
  end

  // Transmitter next state; tx is registered so it changes on the transition edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            frame_done = 1'b1;
            tx_d       = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wptr_q] <= bus.wdata[7:0];
    end
  end

  // Control/status registers, read pipeline and irq
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      timer_q <= '0;
      cmp_q   <= '1;
      pend_q  <= '0;
      en_q    <= '0;
      irq_q   <= 1'b0;
      sel_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      irq_q   <= |(pend_q & en_q);
      sel_q   <= hit;
      rd_q    <= rd_d;
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.rdata = sel_q ? rd_q : bus.mem_rdata;
  assign tx        = tx_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed bench for mmio_uart_responder: register/pass-through vector table,
// then hand-written sequences for serial framing, FIFO overflow, timer
// compare and reset during a frame.
module tb_mmio_uart_responder;

  localparam int CPB = 16;
  localparam logic [31:0] A_TX   = 32'hFFFF_FF00;
  localparam logic [31:0] A_ST   = 32'hFFFF_FF04;
  localparam logic [31:0] A_TM   = 32'hFFFF_FF08;
  localparam logic [31:0] A_CMP  = 32'hFFFF_FF0C;
  localparam logic [31:0] A_PEND = 32'hFFFF_FF10;
  localparam logic [31:0] A_EN   = 32'hFFFF_FF14;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, irq;
  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_bytes [16];
  logic [31:0] rv;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rd;
    logic        exp_g;
  } vec_t;
  vec_t vq[$];

  mmio_uart_responder_if bus_if();

  mmio_uart_responder #(
    .BASE_ADDR(32'hFFFF_FF00),
    .FIFO_DEPTH(8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .tx(tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add_vec(input string n, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] m, input logic [31:0] e, input logic g);
    vec_t v;
    v.name = n; v.wr = w; v.addr = a; v.wdata = d; v.mrd = m; v.exp_rd = e; v.exp_g = g;
    vq.push_back(v);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a; bus_if.wdata = d; bus_if.mem_wr = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_wr = 1'b0; bus_if.addr = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a; bus_if.mem_wr = 1'b0;
    @(posedge clk); #1;
    d = bus_if.rdata;
  endtask

  // Follows tx cycle by cycle from the edge after the call, one frame per
  // exp_bytes entry; reports the mid-bit samples and any off-pattern cycles.
  task automatic tx_monitor(input int nframes);
    for (int f = 0; f < nframes; f++) begin
      logic [9:0] want, got;
      int bad;
      bad  = 0;
      got  = '0;
      want = {1'b1, exp_bytes[f], 1'b0};
      for (int c = 0; c < 10 * CPB; c++) begin
        @(posedge clk); #1;
        if (tx !== want[c / CPB]) bad++;
        if ((c % CPB) == (CPB / 2)) got[c / CPB] = tx;
      end
      check($sformatf("frame%0d_bits", f), {22'h0, got}, {22'h0, want});
      check($sformatf("frame%0d_cycles_off", f), bad, 0);
    end
  endtask

  initial begin
    bus_if.addr = '0; bus_if.wdata = '0; bus_if.mem_wr = 1'b0; bus_if.mem_rdata = '0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b0);
    bus_if.mem_rdata = 32'h1357_9BDF;
    #1;
    check("rst_passthru", bus_if.rdata, 32'h1357_9BDF);
    @(negedge clk);
    reset = 1'b1;

    // Register map and pass-through table
    add_vec("st_reset",     0, A_ST,          0,            32'hDEADBEEF, 32'h0000_0002, 0);
    add_vec("cmp_reset",    0, A_CMP,         0,            32'h0,        32'hFFFF_FFFF, 0);
    add_vec("rd_mem",       0, 32'h0000_0040, 0,            32'h1234_5678, 32'h1234_5678, 0);
    add_vec("wr_mem",       1, 32'h0000_0040, 32'h55,       32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    add_vec("wr_cmp_old",   1, A_CMP,         32'h1234,     32'h0,        32'hFFFF_FFFF, 0);
    add_vec("rd_cmp",       0, A_CMP,         0,            32'h0,        32'h0000_1234, 0);
    add_vec("rd_mem2",      0, 32'h0000_0040, 0,            32'hA0A0_A0A0, 32'hA0A0_A0A0, 0);
    add_vec("wr_below_win", 1, 32'hFFFF_FEFC, 32'h1,        32'h77,       32'h0000_0077, 1);
    add_vec("wr_en",        1, A_EN,          32'hFFFF_FFFF, 32'h0,       32'h0,         0);
    add_vec("rd_en",        0, A_EN,          0,            32'h0,        32'h3,         0);
    add_vec("rd_txdata",    0, A_TX,          0,            32'h1,        32'h0,         0);
    add_vec("wr_unmapped",  1, 32'hFFFF_FF20, 32'hFFFF_FFFF, 32'h5,       32'h0,         0);
    add_vec("rd_unmapped",  0, 32'hFFFF_FF20, 0,            32'h5,        32'h0,         0);
    add_vec("rd_cmp_byte3", 0, 32'hFFFF_FF0F, 0,            32'h0,        32'h0000_1234, 0);
    add_vec("rd_pend",      0, A_PEND,        0,            32'h9,        32'h0,         0);
    add_vec("wr_en0",       1, A_EN,          32'h0,        32'h0,        32'h3,         0);
    add_vec("rd_en0",       0, A_EN,          0,            32'h0,        32'h0,         0);
    add_vec("st_idle",      0, A_ST,          0,            32'h0,        32'h0000_0002, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      bus_if.addr = vq[i].addr; bus_if.wdata = vq[i].wdata;
      bus_if.mem_wr = vq[i].wr; bus_if.mem_rdata = vq[i].mrd;
      #1;
      check({vq[i].name, "_gated"}, bus_if.mem_wr_gated, vq[i].exp_g);
      @(posedge clk); #1;
      check({vq[i].name, "_rdata"}, bus_if.rdata, vq[i].exp_rd);
    end
    bus_if.mem_wr = 1'b0;
    check("irq_quiet", irq, 1'b0);

    // Single frame 0xA5 with frame-done interrupt enabled
    bus_write(A_EN, 32'h2);
    exp_bytes[0] = 8'hA5;
    bus_write(A_TX, 32'hA5);
    bus_if.addr = A_ST;
    fork
      tx_monitor(1);
      begin
        @(posedge clk); #1;
        check("st_count1", bus_if.rdata, 32'h10);
        repeat (158) @(posedge clk);
        #1;
        check("st_busy_stop", bus_if.rdata, 32'h06);
      end
    join
    @(posedge clk); #1;
    check("tx_after_frame", tx, 1'b1);
    check("irq_lag", irq, 1'b0);
    check("st_busy_last", bus_if.rdata, 32'h06);
    @(posedge clk); #1;
    check("st_after_frame", bus_if.rdata, 32'h02);
    check("irq_rise", irq, 1'b1);
    bus_read(A_PEND, rv);
    check("pend_frame", rv, 32'h2);
    bus_write(A_PEND, 32'h2);
    bus_read(A_PEND, rv);
    check("pend_w1c", rv, 32'h0);
    check("irq_fall", irq, 1'b0);

    // Overflow: one byte in flight, then nine pushes into the empty FIFO
    exp_bytes[0] = 8'h3C;
    for (int i = 1; i <= 8; i++) exp_bytes[i] = 8'(i * 17);
    bus_write(A_TX, 32'h3C);
    fork
      tx_monitor(9);
      begin
        repeat (3) @(posedge clk);
        for (int i = 1; i <= 9; i++) bus_write(A_TX, 32'(i * 17));
        bus_read(A_ST, rv);
        check("st_ovf", rv, 32'h8D);
        bus_write(A_ST, 32'h08);
        bus_read(A_ST, rv);
        check("st_ovf_clr", rv, 32'h85);
      end
    join
    @(posedge clk);
    bus_read(A_ST, rv);
    check("st_drained", rv, 32'h02);

    // Timer wrap and compare
    bus_write(A_CMP, 32'h1);
    bus_write(A_PEND, 32'h3);
    bus_write(A_EN, 32'h1);
    bus_write(A_TM, 32'hFFFF_FFFE);
    bus_read(A_TM, rv);
    check("tm_loaded", rv, 32'hFFFF_FFFE);
    bus_read(A_TM, rv);
    check("tm_max", rv, 32'hFFFF_FFFF);
    bus_read(A_TM, rv);
    check("tm_wrap", rv, 32'h0);
    bus_read(A_PEND, rv);
    check("pend0_before", rv, 32'h0);
    check("irq_before", irq, 1'b0);
    bus_read(A_PEND, rv);
    check("pend0_set", rv, 32'h1);
    check("irq_timer", irq, 1'b1);
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rv);
    check("pend0_w1c", rv, 32'h0);
    bus_write(A_TM, 32'h0);
    bus_read(A_PEND, rv);
    check("pend0_pre_race", rv, 32'h0);
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rv);
    check("pend0_set_wins", rv, 32'h1);
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rv);
    check("pend0_clr_again", rv, 32'h0);
    bus_write(A_EN, 32'h0);

    // Reset during DATA bit 3 of a 0x00 frame with more bytes queued
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'h55);
    bus_write(A_TX, 32'h66);
    repeat (68) @(posedge clk);
    #1;
    check("tx_bit3_low", tx, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("tx_reset_high", tx, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (tx !== 1'b1) bad++;
      end
      check("tx_quiet_after_reset", bad, 0);
    end
    bus_read(A_ST, rv);
    check("st_after_reset", rv, 32'h02);
    bus_read(A_CMP, rv);
    check("cmp_after_reset", rv, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_responder.md
# mmio_uart_responder

Memory-mapped I/O responder sitting between the CPU's memory port and `Memoria`. It decodes a 256-byte window at the top of the address space and serves CPU loads and stores there with the same one-cycle read latency as `Memoria`, so the control unit needs no new states. Inside the window it holds a transmit FIFO feeding an 8N1 serial transmitter, a free-running timer with a compare register, and a maskable interrupt line. Accesses outside the window pass through to `Memoria` unchanged.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: window base; window is `addr[31:8] == BASE_ADDR[31:8]`.
- `FIFO_DEPTH`, default 8: TX FIFO entries, power of two, ≤ 15.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, ≥ 2.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low (`reset == 0` at a rising edge resets all state).
- `addr` in 32: CPU memory address (the `MemAddr` mux output).
- `mem_wr` in 1: CPU write strobe (`Memory_WR`).
- `wdata` in 32: CPU write data (the `MemWD` mux output).
- `mem_rdata` in 32: `Memoria` read data.
- `rdata` out 32: read data to IR/MDR.
- `mem_wr_gated` out 1: write strobe to `Memoria`.
- `tx` out 1: serial output, idle high.
- `irq` out 1: interrupt request, registered.

## Operation
- `hit = (addr[31:8] == BASE_ADDR[31:8])`. Offset is `addr[7:2]`; `addr[1:0]` is ignored.
- `mem_wr_gated = mem_wr & ~hit`, combinational. Stores into the window never reach `Memoria`.
- Read path: `sel_q <= hit` and `rd_q <= register(offset)` at every edge. `rdata = sel_q ? rd_q : mem_rdata`.
- Register map (byte offsets):
  - 0x00 TXDATA: W pushes `wdata[7:0]`; R returns 0.
  - 0x04 STATUS: R `[0]` full, `[1]` empty, `[2]` busy, `[3]` ovf, `[7:4]` count, other bits 0. W with `wdata[3]=1` clears ovf.
  - 0x08 TIMER: R returns the counter. W loads `wdata`; no increment on the write cycle. Otherwise the counter increments every cycle and wraps from 0xFFFFFFFF to 0.
  - 0x0C CMP: R/W, 32 bits.
  - 0x10 IRQ_PEND: R `[1:0]`; W1C.
  - 0x14 IRQ_EN: R/W `[1:0]`.
  - Any other offset reads 0; writes to it are ignored.
- FIFO:
  - Full is judged on the count before the edge. A push while full is dropped and sets ovf, even if a pop occurs on the same cycle.
  - A push and a pop on the same edge, when not full, leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - IDLE → START when the FIFO is non-empty. The head is popped into the shift register on this transition.
  - START drives `tx=0`. DATA sends 8 bits, LSB first. STOP drives `tx=1`. Each bit lasts `CLKS_PER_BIT` cycles.
  - At the end of STOP: go to START with a pop if the FIFO is non-empty, else go to IDLE.
  - busy = (state != IDLE).
- Interrupts:
  - `pend[0]` sets on a cycle where TIMER == CMP, comparing the value before increment or load.
  - `pend[1]` sets on the STOP → IDLE transition.
  - If a set and a W1C hit the same bit on the same cycle, the set wins.
  - `irq <= |(pend & en)`.

## Timing
- Reset values:
  - Outputs: `tx=1`, `irq=0`, `sel_q=0` (so `rdata=mem_rdata`), `rd_q=0`.
  - State: FIFO empty, ovf=0, TIMER=0, CMP=0xFFFFFFFF, pend=0, en=0, FSM=IDLE.
- Read latency is 1 cycle: address presented before edge N, data valid after edge N. This matches `Memoria`.
- Register writes take effect at the edge where `mem_wr & hit` is sampled. A read at edge N+1 sees the new value.
- Push at edge N → pop and START at edge N+1 → `tx` low from N+1 through N+1+`CLKS_PER_BIT`. A full frame is `10*CLKS_PER_BIT` cycles.
- Back-to-back frames have no idle gap.
- `irq` lags its pending or enable cause by 1 cycle.
- Reset asserted mid-frame: `tx=1` at the next edge, FIFO contents are discarded, and no partial bits follow.

## Test plan
- Reset check: hold `reset=0` for 2 cycles → `tx=1`, `irq=0`, STATUS reads 0x02, CMP reads 0xFFFFFFFF, `rdata` follows `mem_rdata`.
- Pass-through: store to 0x0000_0040 → `mem_wr_gated=1`. Store to 0xFFFF_FF0C → `mem_wr_gated=0`; reading 0xFFFF_FF0C then returns the stored value one cycle later, while reading 0x40 returns `mem_rdata`.
- Serial frame: push 0xA5 with `CLKS_PER_BIT=16` → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. STATUS busy clears after 160 cycles. With en=2, `pend[1]` sets and `irq` rises one cycle later.
- FIFO overflow: push 9 bytes back-to-back while the transmitter is stalled at the start of the first frame → the 9th write is dropped, STATUS shows ovf=1; writing 0x08 to STATUS clears ovf. All 8 accepted bytes then transmit in order with no gaps.
- Timer: write TIMER=0xFFFFFFFE and CMP=0x00000001, en=1 → TIMER wraps to 0; `pend[0]` sets two cycles after the wrap; W1C issued on the same cycle as a new match leaves `pend[0]=1`.
- Reset mid-frame: assert reset during DATA bit 3 → `tx=1` at the next edge and STATUS reads empty afterward.
